fft4_peak_picker: RTL and testbench

- Sits directly downstream of the combinational 4-point FFT (FFT4) in the tuner datapath.
- Captures one frame of FFT outputs on Start, then scans the unique bins one per clock. The FFT input is real, so bin 3 is the conjugate of bin 1 and is never scanned.
- For each scanned bin it forms an L1 magnitude |Re|+|Im| and reports the strongest bin and its magnitude with a Done pulse.
- Feeds the pitch-estimation stage.

---
 rtl/fft4_peak_picker.sv | 137 +++++++++++++
 tb/tb_fft4_peak_picker.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft4_peak_picker.sv
// Peak picker behind the FFT4: latches one frame on Start, scans bins 0..2 (or 1..2)
// one per clock, and reports the strongest bin by L1 magnitude with a Done pulse.
module fft4_peak_picker #(
    parameter int PRE     = 16,
    parameter bit SKIP_DC = 1'b0
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        Start,
    input  logic signed [2*PRE:0]       Y0_Re,
    input  logic signed [2*PRE:0]       Y1_Re,
    input  logic signed [2*PRE:0]       Y2_Re,
    input  logic signed [2*PRE:0]       Y3_Re,
    input  logic signed [2*PRE:0]       Y0_Im,
    input  logic signed [2*PRE:0]       Y1_Im,
    input  logic signed [2*PRE:0]       Y2_Im,
    input  logic signed [2*PRE:0]       Y3_Im,
    input  logic        [2*PRE+1:0]     Threshold,
    output logic                        Busy,
    output logic                        Done,
    output logic        [1:0]           Peak_Bin,
    output logic        [2*PRE+1:0]     Peak_Mag,
    output logic                        Peak_Valid
);

    localparam int W  = 2*PRE+1;
    localparam int MW = 2*PRE+2;
    localparam logic [1:0] FIRST_IDX = SKIP_DC ? 2'd1 : 2'd0;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                state_q, state_d;
    logic signed [W-1:0]   re_q [3];
    logic signed [W-1:0]   im_q [3];
    logic        [1:0]     idx_q;
    logic        [MW-1:0]  best_q;
    logic        [1:0]     best_idx_q;
    logic        [1:0]     peak_bin_q;
    logic        [MW-1:0]  peak_mag_q;
    logic                  peak_valid_q;

    logic                  accept;
    logic signed [W-1:0]   sel_re, sel_im;
    logic        [MW-1:0]  mag_cur, best_d;
    logic        [1:0]     best_idx_d;
    logic                  take;

    // Bin 3 mirrors bin 1 for real input, so it is never looked at.
    logic unused_y3;
    assign unused_y3 = ^{Y3_Re, Y3_Im};

    // Sign-extend before negating so the most-negative input does not wrap.
    function automatic logic [MW-1:0] abs_ext(input logic signed [W-1:0] x);
        logic signed [MW-1:0] e;
        e = {x[W-1], x};
        return e[MW-1] ? MW'(-e) : MW'(e);
    endfunction

    assign accept = Start && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        sel_re = re_q[0];
        sel_im = im_q[0];
        case (idx_q)
            2'd1: begin sel_re = re_q[1]; sel_im = im_q[1]; end
            2'd2: begin sel_re = re_q[2]; sel_im = im_q[2]; end
            default: ;
        endcase
    end

    assign mag_cur    = abs_ext(sel_re) + abs_ext(sel_im);
    assign take       = (idx_q == FIRST_IDX) || (mag_cur > best_q);
    assign best_d     = take ? mag_cur : best_q;
    assign best_idx_d = take ? idx_q : best_idx_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = SCAN;
            SCAN:    if (idx_q == 2'd2) state_d = DONE;
            DONE:    state_d = Start ? SCAN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Busy = (state_q == SCAN);
        Done = (state_q == DONE);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 3; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
            idx_q        <= '0;
            best_q       <= '0;
            best_idx_q   <= '0;
            peak_bin_q   <= '0;
            peak_mag_q   <= '0;
            peak_valid_q <= 1'b0;
        end else if (accept) begin
            re_q[0]    <= Y0_Re;
            re_q[1]    <= Y1_Re;
            re_q[2]    <= Y2_Re;
            im_q[0]    <= Y0_Im;
            im_q[1]    <= Y1_Im;
            im_q[2]    <= Y2_Im;
            idx_q      <= FIRST_IDX;
            best_q     <= '0;
            best_idx_q <= '0;
        end else if (state_q == SCAN) begin
            idx_q      <= idx_q + 2'd1;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            if (idx_q == 2'd2) begin
                peak_bin_q   <= best_idx_d;
                peak_mag_q   <= best_d;
                peak_valid_q <= (best_d >= Threshold);
            end
        end
    end

    assign Peak_Bin   = peak_bin_q;
    assign Peak_Mag   = peak_mag_q;
    assign Peak_Valid = peak_valid_q;

endmodule

// File: tb/tb_fft4_peak_picker.sv
// Directed bench for fft4_peak_picker: one DUT with DC scanned, one with DC skipped,
// sharing stimulus; expected values are hand-computed L1 magnitudes.
module tb_fft4_peak_picker;

    localparam int PRE = 16;
    localparam int W   = 2*PRE+1;
    localparam int MW  = 2*PRE+2;

    logic                 Clk = 1'b0;
    logic                 Reset;
    logic                 Start;
    logic signed [W-1:0]  Y0_Re, Y1_Re, Y2_Re, Y3_Re;
    logic signed [W-1:0]  Y0_Im, Y1_Im, Y2_Im, Y3_Im;
    logic        [MW-1:0] Threshold;

    logic          busy0, done0, valid0, busy1, done1, valid1;
    logic [1:0]    bin0, bin1;
    logic [MW-1:0] mag0, mag1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    fft4_peak_picker #(.PRE(PRE), .SKIP_DC(1'b0)) u_dut0 (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .Y0_Re(Y0_Re), .Y1_Re(Y1_Re), .Y2_Re(Y2_Re), .Y3_Re(Y3_Re),
        .Y0_Im(Y0_Im), .Y1_Im(Y1_Im), .Y2_Im(Y2_Im), .Y3_Im(Y3_Im),
        .Threshold(Threshold), .Busy(busy0), .Done(done0),
        .Peak_Bin(bin0), .Peak_Mag(mag0), .Peak_Valid(valid0)
    );

    fft4_peak_picker #(.PRE(PRE), .SKIP_DC(1'b1)) u_dut1 (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .Y0_Re(Y0_Re), .Y1_Re(Y1_Re), .Y2_Re(Y2_Re), .Y3_Re(Y3_Re),
        .Y0_Im(Y0_Im), .Y1_Im(Y1_Im), .Y2_Im(Y2_Im), .Y3_Im(Y3_Im),
        .Threshold(Threshold), .Busy(busy1), .Done(done1),
        .Peak_Bin(bin1), .Peak_Mag(mag1), .Peak_Valid(valid1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_y(input logic signed [W-1:0] r0, i0, r1, i1, r2, i2);
        Y0_Re = r0; Y0_Im = i0;
        Y1_Re = r1; Y1_Im = i1;
        Y2_Re = r2; Y2_Im = i2;
        Y3_Re = r1; Y3_Im = -i1;
    endtask

    // Pulses Start over one edge, then waits (bounded) for both Done pulses.
    // Latencies count edges from the accepting edge inclusive.
    task automatic run_frame(output int lat0, output int lat1, output int nd0, output int nd1);
        lat0 = -1; lat1 = -1; nd0 = 0; nd1 = 0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int e = 2; e <= 8; e++) begin
            tick();
            if (done0) begin nd0++; if (lat0 < 0) lat0 = e; end
            if (done1) begin nd1++; if (lat1 < 0) lat1 = e; end
        end
    endtask

    int  l0, l1, c0, c1, n;
    bit  seen;
    logic signed [W-1:0] neg_max;

    initial begin
        neg_max   = {1'b1, {(W-1){1'b0}}};
        Reset     = 1'b0;
        Start     = 1'b1;
        Threshold = '0;
        set_y(0, 0, 0, 0, 0, 0);

        // Reset with Start held
        tick(); tick();
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_bin",  bin0, 0);
        check("rst_mag",  mag0, 0);
        check("rst_valid", valid0, 0);
        Start = 1'b0;
        #2 Reset = 1'b1;
        seen = 0;
        for (int e = 0; e < 4; e++) begin
            tick();
            if (done0 || busy0 || done1 || busy1) seen = 1;
        end
        check("idle_no_activity", seen, 0);

        // Frame A
        set_y(-482739591, 0, 322112716, 107370905, -161485842, 0);
        run_frame(l0, l1, c0, c1);
        check("A_lat0", l0, 4);
        check("A_lat1", l1, 3);
        check("A_ndone0", c0, 1);
        check("A_ndone1", c1, 1);
        check("A_bin0", bin0, 0);
        check("A_mag0", mag0, 482739591);
        check("A_valid0", valid0, 1);
        check("A_bin1", bin1, 1);
        check("A_mag1", mag1, 429483621);
        check("A_idle_busy", busy0, 0);

        // Frame A then Frame B back-to-back on the DC-scanning instance
        set_y(0, 0, 0, 0, 0, 0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        set_y(-482739591, 0, 322112716, 107370905, -161485842, 0);
        n = 0;
        while (!done0 && n < 10) begin
            if (n == 0) begin
                // Frame buffer captured zeros; late input changes must not leak in.
            end
            tick();
            n++;
        end
        check("AB_wait_done", done0, 1);
        check("AZ_mag0", mag0, 0);
        set_y(-482739591, 0, 322112716, 107370905, -161485842, 0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        n = 0;
        while (!done0 && n < 10) begin tick(); n++; end
        check("A2_wait_done", done0, 1);
        check("A2_mag0", mag0, 482739591);
        // Start B in A's DONE cycle
        set_y(164062743, 0, -54544420, 271004165, 51538034, 0);
        Threshold = 400000000;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("B_busy", busy0, 1);
        set_y(-482739591, 0, 322112716, 107370905, -161485842, 0);
        tick();
        check("B_hold_mag", mag0, 482739591);
        check("B_hold_bin", bin0, 0);
        tick();
        check("B_not_done_yet", done0, 0);
        tick();
        check("B_done", done0, 1);
        check("B_bin0", bin0, 1);
        check("B_mag0", mag0, 325548585);
        check("B_valid0", valid0, 0);
        tick();
        check("B_done_pulse_end", done0, 0);
        Threshold = '0;

        // Ties keep the lower index
        set_y(0, 0, 100, -50, -75, 75);
        run_frame(l0, l1, c0, c1);
        check("tie_bin0", bin0, 1);
        check("tie_mag0", mag0, 150);
        check("tie_bin1", bin1, 1);

        // Most-negative input must not wrap
        set_y(0, 0, 0, 0, neg_max, neg_max);
        run_frame(l0, l1, c0, c1);
        check("ext_bin0", bin0, 2);
        check("ext_mag0", mag0, 64'h2_0000_0000);
        check("ext_valid0", valid0, 1);

        // Start pulsed mid-scan is ignored
        set_y(7, 0, 3, 3, 1, -1);
        Start = 1'b1;
        tick();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        c0 = 0; c1 = 0;
        for (int e = 0; e < 8; e++) begin
            if (done0) c0++;
            if (done1) c1++;
            tick();
        end
        check("ign_ndone0", c0, 1);
        check("ign_ndone1", c1, 1);
        check("ign_bin0", bin0, 0);
        check("ign_mag0", mag0, 7);
        check("ign_mag1", mag1, 6);

        // Reset in the second scan cycle aborts the frame
        set_y(0, 0, 500, 0, 0, 0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        Reset = 1'b0;
        #2;
        check("abort_busy", busy0, 0);
        check("abort_mag", mag0, 0);
        check("abort_bin", bin0, 0);
        check("abort_valid", valid0, 0);
        #2 Reset = 1'b1;
        seen = 0;
        for (int e = 0; e < 6; e++) begin
            tick();
            if (done0 || done1) seen = 1;
        end
        check("abort_no_done", seen, 0);
        check("abort_mag_after", mag0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
